// File: rtl/exp_driver.sv
// exp_driver
//   Initiator-side sequencer for the exponential accelerator. Operands
//   arrive on a valid/ready stream and wait in a small FIFO. Each operand is
//   driven onto x with a one-cycle start pulse. The result is captured into a
//   register that is presented on a second valid/ready stream. A watchdog
//   abandons an operation whose done never arrives, so a hung accelerator
//   cannot stall the stream.
//
// Parameters
//   DEPTH    operand FIFO entries (power of two, >= 2)
//   TIMEOUT  maximum cycles spent waiting for done before abort
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   in_valid   operand available
//   in_data    operand (Q0.16 fraction)
//   in_ready   FIFO not full
//   x          operand to the accelerator, stable from start until next issue
//   start      one-cycle start pulse to the accelerator
//   done       accelerator completion (level, may stay high until next start)
//   intpart    accelerator integer result
//   fracpart   accelerator fractional result
//   out_valid  result register full
//   out_int    captured integer part
//   out_frac   captured fractional part
//   out_ready  consumer accepts the result
//   busy       sequencer not idle
//   err        sticky timeout flag, cleared only by reset
//   ops_done   completed-operation count, wraps 255 -> 0

module exp_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [15:0] x,
    output logic        start,
    input  logic        done,
    input  logic [1:0]  intpart,
    input  logic [15:0] fracpart,
    output logic        out_valid,
    output logic [1:0]  out_int,
    output logic [15:0] out_frac,
    input  logic        out_ready,
    output logic        busy,
    output logic        err,
    output logic [7:0]  ops_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        GUARD,
        WAIT
    } state_t;

    state_t         state;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [WW-1:0]  wd;
    logic           push;
    logic           pop;
    logic           drain;

    // Issue only when the result register is free or being emptied this
    // edge, so a stalled consumer never has a result overwritten.
    always_comb begin
        in_ready = (count != CW'(DEPTH));
        push     = in_valid && in_ready;
        drain    = out_valid && out_ready;
        pop      = (state == IDLE) && (count != '0) && (!out_valid || out_ready);
    end

    assign busy = (state != IDLE);

    // Operand storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            x         <= '0;
            start     <= 1'b0;
            out_valid <= 1'b0;
            out_int   <= '0;
            out_frac  <= '0;
            err       <= 1'b0;
            ops_done  <= '0;
            wd        <= '0;
        end else begin
            start <= 1'b0;
            // A capture later in this block overrides the drain.
            if (drain) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        x     <= mem[rd_ptr];
                        start <= 1'b1;
                        state <= START;
                    end
                end
                // done may still be high from the previous operation, so it
                // is not looked at until WAIT.
                START: begin
                    state <= GUARD;
                end
                GUARD: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        out_int   <= intpart;
                        out_frac  <= fracpart;
                        out_valid <= 1'b1;
                        ops_done  <= ops_done + 8'd1;
                        state     <= IDLE;
                    end else if (wd == WW'(TIMEOUT - 1)) begin
                        // TIMEOUT-th WAIT cycle without done: drop the operand.
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_driver.sv
module tb_exp_driver;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1023;
    localparam int LAT     = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] x;
    logic        start;
    logic        done;
    logic [1:0]  intpart;
    logic [15:0] fracpart;
    logic        out_valid;
    logic [1:0]  out_int;
    logic [15:0] out_frac;
    logic        out_ready;
    logic        busy;
    logic        err;
    logic [7:0]  ops_done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit tmo_mode = 1'b0;

    always #5 clk = ~clk;

    exp_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .x(x), .start(start), .done(done),
        .intpart(intpart), .fracpart(fracpart),
        .out_valid(out_valid), .out_int(out_int), .out_frac(out_frac),
        .out_ready(out_ready),
        .busy(busy), .err(err), .ops_done(ops_done)
    );

    // Accelerator stub: done rises LAT cycles after the start edge and stays
    // high (stale) until two edges into the next operation.
    logic [15:0] sx;
    int          scnt;
    assign intpart  = sx[15:14];
    assign fracpart = ~sx;

    always @(posedge clk) begin
        if (!rst) begin
            done <= 1'b0;
            scnt <= 0;
            sx   <= '0;
        end else if (start) begin
            scnt <= 1;
            sx   <= x;
        end else if (scnt != 0 && scnt < 100) begin
            scnt <= scnt + 1;
            if (scnt + 1 == 2) done <= 1'b0;
            if (scnt + 1 == LAT - 1 && !tmo_mode) done <= 1'b1;
        end
    end

    // Behavioural model: operands in a queue, each operation a timeline
    // measured in edges since its issue (result at LAT, abort at TIMEOUT+2).
    logic [15:0] mq[$];
    int          m_t = -1;
    bit          m_top;
    logic [15:0] m_x, m_cur, m_frac;
    logic [1:0]  m_int;
    logic        m_ov, m_err, m_start;
    logic [7:0]  m_ops;

    always @(posedge clk) begin : model_p
        bit idle, issue, psh, fin_ok, fin_to;
        if (!rst) begin
            mq.delete();
            m_t = -1; m_x = '0; m_cur = '0; m_frac = '0; m_int = '0;
            m_ov = 1'b0; m_err = 1'b0; m_start = 1'b0; m_ops = '0;
        end else begin
            idle   = (m_t < 0);
            issue  = idle && (mq.size() > 0) && (!m_ov || out_ready);
            psh    = in_valid && (mq.size() < DEPTH);
            fin_ok = 1'b0;
            fin_to = 1'b0;
            if (!idle) begin
                m_t = m_t + 1;
                if (!m_top && m_t == LAT) fin_ok = 1'b1;
                if (m_top && m_t == TIMEOUT + 2) fin_to = 1'b1;
            end
            if (fin_ok) begin
                m_ov   = 1'b1;
                m_int  = m_cur[15:14];
                m_frac = ~m_cur;
                m_ops  = m_ops + 8'd1;
                m_t    = -1;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (fin_to) begin
                m_err = 1'b1;
                m_t   = -1;
            end
            m_start = issue;
            if (issue) begin
                m_x   = mq.pop_front();
                m_cur = m_x;
                m_t   = 0;
                m_top = tmo_mode;
            end
            if (psh) mq.push_back(in_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and per-cycle compare, away from the active edge.
    int          cyc_n = 0;
    int          n_starts = 0;
    int          last_start_cyc = 0;
    int          err_first = -1;
    logic [17:0] hs_log[$];

    always @(negedge clk) begin
        cyc_n++;
        if (!rst) err_first = -1;
        else if (err && err_first < 0) err_first = cyc_n;
        if (start) begin
            n_starts++;
            last_start_cyc = cyc_n;
        end
        if (out_valid && out_ready) hs_log.push_back({out_int, out_frac});
        if (chk_en) begin
            chk("start", start, m_start);
            chk("x", x, m_x);
            chk("in_ready", in_ready, mq.size() != DEPTH);
            chk("busy", busy, m_t >= 0);
            chk("out_valid", out_valid, m_ov);
            chk("out_int", out_int, m_int);
            chk("out_frac", out_frac, m_frac);
            chk("err", err, m_err);
            chk("ops_done", ops_done, m_ops);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] d);
        bit acc = 1'b0;
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && k < 200) begin
            acc = in_ready;
            cyc(1);
            k++;
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_hs(input int n, input int budget, input string name);
        int k = 0;
        while (hs_log.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk(name, hs_log.size(), n);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
    endtask

    initial begin
        int base, s0, k;
        logic [15:0] exp_frac [5];
        exp_frac[0] = 16'h7FFF; exp_frac[1] = 16'h3333; exp_frac[2] = 16'hCCCC;
        exp_frac[3] = 16'h028F; exp_frac[4] = 16'hFD70;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x", x, 0);
        chk("rst_ops_done", ops_done, 0);
        rst = 1'b1;

        // Single operation
        base = hs_log.size();
        push(16'h8000);
        wait_hs(base + 1, 100, "single_result");
        if (hs_log.size() > base) chk("single_value", hs_log[base], {2'b10, 16'h7FFF});
        chk("single_ops_done", ops_done, 1);

        // Stream of five, FIFO fills
        do_reset();
        base = hs_log.size();
        s0 = n_starts;
        push(16'h8000); push(16'hCCCC); push(16'h3333); push(16'hFD70); push(16'h028F);
        chk("stream_full", in_ready, 0);
        wait_hs(base + 5, 300, "stream_results");
        for (int i = 0; i < 5; i++)
            if (hs_log.size() > base + i) chk("stream_frac", hs_log[base + i][15:0], exp_frac[i]);
        chk("stream_ops_done", ops_done, 5);
        chk("stream_starts", n_starts - s0, 5);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        base = hs_log.size();
        s0 = n_starts;
        push(16'h8000); push(16'hCCCC);
        k = 0;
        while (!out_valid && k < 100) begin cyc(1); k++; end
        chk("bp_first_valid", out_valid, 1);
        cyc(30);
        chk("bp_one_start", n_starts - s0, 1);
        chk("bp_idle", busy, 0);
        out_ready = 1'b1;
        cyc(1);
        chk("bp_release_start", start, 1);
        wait_hs(base + 2, 100, "bp_results");
        if (hs_log.size() > base + 1) chk("bp_second", hs_log[base + 1][15:0], 16'h3333);

        // Watchdog timeout, then recovery
        do_reset();
        tmo_mode = 1'b1;
        base = hs_log.size();
        push(16'h1234);
        k = 0;
        while (err_first < 0 && k < 1200) begin cyc(1); k++; end
        chk("tmo_err", err, 1);
        chk("tmo_latency", err_first - last_start_cyc, TIMEOUT + 2);
        chk("tmo_no_result", hs_log.size(), base);
        chk("tmo_ops_done", ops_done, 0);
        tmo_mode = 1'b0;
        push(16'h4000);
        wait_hs(base + 1, 100, "tmo_recover");
        if (hs_log.size() > base) chk("tmo_recover_val", hs_log[base], {2'b01, 16'hBFFF});
        chk("tmo_err_sticky", err, 1);

        // Reset mid-WAIT with two operands queued
        do_reset();
        push(16'h1111); push(16'h2222); push(16'h3333);
        cyc(5);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_start", start, 0);
        chk("mid_x", x, 0);
        s0 = n_starts;
        base = hs_log.size();
        cyc(40);
        chk("mid_no_start", n_starts - s0, 0);
        push(16'h0001);
        wait_hs(base + 1, 100, "mid_new_result");
        if (hs_log.size() > base) chk("mid_new_val", hs_log[base], {2'b00, 16'hFFFE});

        // ops_done wraps after 256 completions
        do_reset();
        base = hs_log.size();
        for (int i = 0; i < 256; i++) push(16'(i * 257));
        wait_hs(base + 256, 1000, "wrap_results");
        chk("wrap_ops_done", ops_done, 0);
        if (hs_log.size() > base + 255) chk("wrap_last", hs_log[base + 255][15:0], 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
